// File: rtl/pmod_led_fader_if.sv
// Pmod LED fader interface: the sequencer-side controls in, PWM pins and status out.
interface pmod_led_fader_if #(
    parameter int unsigned CH = 8
);
    logic          enable;
    logic          tick;
    logic [CH-1:0] pattern;
    logic [CH-1:0] led;
    logic          active;
    logic          tick_drop;

    // Sequencer side: drives run control, tick and pattern; observes the LEDs.
    modport master (
        output enable,
        output tick,
        output pattern,
        input  led,
        input  active,
        input  tick_drop
    );

    // Fader side: consumes run control, tick and pattern; drives the LED pins.
    modport slave (
        input  enable,
        input  tick,
        input  pattern,
        output led,
        output active,
        output tick_drop
    );
endinterface : pmod_led_fader_if

// File: rtl/pmod_led_fader.sv
// Per-channel PWM LED fader: lit channels snap to full duty, unlit ones decay one
// step per tick; duty updates land only on the PWM period boundary.
module pmod_led_fader #(
    parameter int unsigned CH        = 8,
    parameter int unsigned PWM_BITS  = 8,
    parameter int unsigned FADE_STEP = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    pmod_led_fader_if.slave   bus
);

    localparam int unsigned DUTY_MAX_I = (1 << PWM_BITS) - 1;
    localparam logic [PWM_BITS-1:0] DUTY_MAX = PWM_BITS'(DUTY_MAX_I);
    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(DUTY_MAX_I - 1);
    localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(FADE_STEP);

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] duty_q [CH];
    logic [PWM_BITS-1:0] duty_d [CH];
    logic                tick_prev_q, tick_prev_d;
    logic                tick_pend_q, tick_pend_d;
    logic [CH-1:0]       led_q, led_d;
    logic                active_q, active_d;
    logic                tick_drop_q, tick_drop_d;

    logic                tick_ev;
    logic                boundary;
    logic                apply;

    // Rising-edge tick detect, period boundary and update strobe.
    always_comb begin
        tick_ev  = bus.tick & ~tick_prev_q;
        boundary = (cnt_q == CNT_LAST);
        apply    = bus.enable & boundary & (tick_pend_q | tick_ev);
    end

    // Next-state: counter, pending flag, duty update and registered outputs.
    always_comb begin
        cnt_d       = cnt_q;
        tick_prev_d = bus.tick;
        tick_pend_d = tick_pend_q;
        tick_drop_d = 1'b0;
        led_d       = '0;
        active_d    = 1'b0;
        for (int i = 0; i < int'(CH); i++) begin
            duty_d[i] = duty_q[i];
        end

        if (!bus.enable) begin
            // Blanked: everything but the tick history is cleared.
            cnt_d       = '0;
            tick_pend_d = 1'b0;
            for (int i = 0; i < int'(CH); i++) begin
                duty_d[i] = '0;
            end
        end else begin
            cnt_d = boundary ? '0 : cnt_q + PWM_BITS'(1);

            if (apply) begin
                tick_pend_d = 1'b0;
            end else if (tick_ev) begin
                tick_pend_d = 1'b1;
                // Second edge before the boundary is folded into the pending one.
                tick_drop_d = tick_pend_q;
            end

            if (apply) begin
                for (int i = 0; i < int'(CH); i++) begin
                    if (bus.pattern[i]) begin
                        duty_d[i] = DUTY_MAX;
                    end else if (duty_q[i] >= STEP) begin
                        duty_d[i] = duty_q[i] - STEP;
                    end else begin
                        duty_d[i] = '0;
                    end
                end
            end

            for (int i = 0; i < int'(CH); i++) begin
                led_d[i] = (duty_q[i] > cnt_q);
            end
        end

        // Tracks the duty registers as they will be after this edge.
        for (int i = 0; i < int'(CH); i++) begin
            active_d = active_d | (duty_d[i] != '0);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            tick_prev_q <= 1'b0;
            tick_pend_q <= 1'b0;
            led_q       <= '0;
            active_q    <= 1'b0;
            tick_drop_q <= 1'b0;
            for (int i = 0; i < int'(CH); i++) begin
                duty_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            tick_prev_q <= tick_prev_d;
            tick_pend_q <= tick_pend_d;
            led_q       <= led_d;
            active_q    <= active_d;
            tick_drop_q <= tick_drop_d;
            for (int i = 0; i < int'(CH); i++) begin
                duty_q[i] <= duty_d[i];
            end
        end
    end

    assign bus.led       = led_q;
    assign bus.active    = active_q;
    assign bus.tick_drop = tick_drop_q;

endmodule : pmod_led_fader

// File: tb/tb_pmod_led_fader.sv
// Directed bench for pmod_led_fader: reset, snap-on, fade, tick merge,
// boundary coincidence and enable/reset blanking.
module tb_pmod_led_fader;

    localparam int unsigned CH     = 8;
    localparam int          PERIOD = 255;

    logic clk;
    logic rst_n;

    pmod_led_fader_if #(.CH(CH)) bus ();

    pmod_led_fader #(
        .CH        (CH),
        .PWM_BITS  (8),
        .FADE_STEP (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int tb_cnt  = 0;
    int drop_total = 0;
    int hi [CH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference PWM phase, used only to place stimulus and measurement windows.
    always @(posedge clk) begin
        if (!rst_n || !bus.enable) tb_cnt <= 0;
        else                       tb_cnt <= (tb_cnt == PERIOD - 1) ? 0 : tb_cnt + 1;
    end

    always @(negedge clk) begin
        if (bus.tick_drop === 1'b1) drop_total <= drop_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cnt(input int v);
        int n;
        n = 0;
        while (tb_cnt != v && n < 2 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        if (tb_cnt != v) chk("wait_cnt_timeout", 32'(tb_cnt), 32'(v));
    endtask

    // Counts high cycles per channel over 255 consecutive samples, starting now.
    task automatic count_window();
        for (int i = 0; i < int'(CH); i++) hi[i] = 0;
        for (int k = 0; k < PERIOD; k++) begin
            if (k > 0) @(negedge clk);
            for (int i = 0; i < int'(CH); i++) hi[i] += int'(bus.led[i]);
        end
    endtask

    function automatic int hi_sum();
        int s;
        s = 0;
        for (int i = 0; i < int'(CH); i++) s += hi[i];
        return s;
    endfunction

    task automatic pulse_tick();
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
    endtask

    // Waits past the next boundary and measures the period that follows it.
    task automatic window_after_boundary();
        wait_cnt(PERIOD - 1);
        @(negedge clk);
        wait_cnt(1);
        count_window();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fade_exp [5];
        int base;
        fade_exp = '{191, 127, 63, 0, 0};

        rst_n       = 1'b0;
        bus.enable  = 1'b1;
        bus.pattern = 8'hFF;
        bus.tick    = 1'b0;

        // Reset with tick toggling and all pattern bits set.
        repeat (3) begin
            bus.tick = ~bus.tick;
            @(negedge clk);
            chk("rst_led", 32'(bus.led), 32'h0);
            chk("rst_active", 32'(bus.active), 32'h0);
            chk("rst_drop", 32'(bus.tick_drop), 32'h0);
        end

        // Released with no tick: stays dark.
        bus.tick = 1'b0;
        rst_n    = 1'b1;
        repeat (300) @(negedge clk);
        chk("idle_led", 32'(bus.led), 32'h0);
        chk("idle_active", 32'(bus.active), 32'h0);

        // Snap-on channel 0.
        bus.pattern = 8'h01;
        wait_cnt(10);
        pulse_tick();
        wait_cnt(1);
        count_window();
        chk("snap_ch0", 32'(hi[0]), 32'd255);
        chk("snap_rest", 32'(hi_sum() - hi[0]), 32'd0);
        chk("snap_active", 32'(bus.active), 32'h1);

        // Fade channel 0 with saturation while channel 1 is held lit.
        bus.pattern = 8'h02;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            pulse_tick();
            wait_cnt(1);
            count_window();
            chk($sformatf("fade_ch0_%0d", k), 32'(hi[0]), 32'(fade_exp[k]));
            chk($sformatf("fade_ch1_%0d", k), 32'(hi[1]), 32'd255);
        end
        chk("fade_active", 32'(bus.active), 32'h1);

        // Two edges in one period merge into one update with one drop pulse.
        bus.pattern = 8'h01;
        base = drop_total;
        wait_cnt(10);
        pulse_tick();
        chk("merge_first_nodrop", 32'(bus.tick_drop), 32'h0);
        wait_cnt(50);
        bus.tick = 1'b1;
        @(negedge clk);
        chk("merge_drop_pulse", 32'(bus.tick_drop), 32'h1);
        bus.tick = 1'b0;
        @(negedge clk);
        chk("merge_drop_single", 32'(bus.tick_drop), 32'h0);
        wait_cnt(1);
        count_window();
        chk("merge_ch0", 32'(hi[0]), 32'd255);
        chk("merge_ch1", 32'(hi[1]), 32'd191);
        chk("merge_drops", 32'(drop_total - base), 32'd1);

        // Tick held high over several boundaries counts once.
        base = drop_total;
        wait_cnt(5);
        bus.tick = 1'b1;
        repeat (600) @(negedge clk);
        bus.tick = 1'b0;
        wait_cnt(1);
        count_window();
        chk("hold_ch0", 32'(hi[0]), 32'd255);
        chk("hold_ch1", 32'(hi[1]), 32'd127);
        chk("hold_drops", 32'(drop_total - base), 32'd0);

        // Tick edge exactly on the boundary cycle.
        bus.pattern = 8'h80;
        wait_cnt(PERIOD - 1);
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        chk("coin_led7_cnt0", 32'(bus.led[7]), 32'h0);
        @(negedge clk);
        chk("coin_led7_cnt1", 32'(bus.led[7]), 32'h1);
        count_window();
        chk("coin_ch7", 32'(hi[7]), 32'd255);
        chk("coin_ch1", 32'(hi[1]), 32'd63);
        chk("coin_ch0", 32'(hi[0]), 32'd191);
        wait_cnt(1);
        count_window();
        chk("coin_nopend_ch1", 32'(hi[1]), 32'd63);
        chk("coin_nopend_ch7", 32'(hi[7]), 32'd255);

        // Enable drop with a pending tick: blank now, no update later.
        bus.pattern = 8'hFF;
        wait_cnt(20);
        pulse_tick();
        wait_cnt(100);
        bus.enable = 1'b0;
        @(negedge clk);
        chk("en_drop_led", 32'(bus.led), 32'h0);
        chk("en_drop_active", 32'(bus.active), 32'h0);
        bus.enable = 1'b1;
        window_after_boundary();
        chk("en_pend_discard", 32'(hi_sum()), 32'd0);
        chk("en_pend_active", 32'(bus.active), 32'h0);

        // Counter phase after re-enable: first lit sample right after the boundary.
        bus.pattern = 8'h01;
        @(negedge clk);
        pulse_tick();
        wait_cnt(0);
        chk("phase_cnt0", 32'(bus.led[0]), 32'h0);
        @(negedge clk);
        chk("phase_cnt1", 32'(bus.led[0]), 32'h1);
        chk("phase_active", 32'(bus.active), 32'h1);

        // Tick already high when enable rises is not an event.
        bus.pattern = 8'hFF;
        bus.enable  = 1'b0;
        bus.tick    = 1'b1;
        repeat (3) @(negedge clk);
        bus.enable = 1'b1;
        window_after_boundary();
        chk("en_rise_tick_high", 32'(hi_sum()), 32'd0);
        bus.tick = 1'b0;

        // Reset mid-period with duties lit and a pending tick.
        bus.pattern = 8'h01;
        @(negedge clk);
        pulse_tick();
        window_after_boundary();
        chk("rst_mid_lit", 32'(hi[0]), 32'd255);
        bus.pattern = 8'hFF;
        wait_cnt(20);
        pulse_tick();
        wait_cnt(100);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_led", 32'(bus.led), 32'h0);
        chk("rst_mid_active", 32'(bus.active), 32'h0);
        rst_n = 1'b1;
        window_after_boundary();
        chk("rst_pend_discard", 32'(hi_sum()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pmod_led_fader

// File: doc/pmod_led_fader.md
Name: pmod_led_fader

Overview:
- Downstream stage of the Pmod LED pattern sequencer. It consumes the 8-bit LED pattern and the sequencer's timer tick, and drives the 8 Pmod LED pins through per-channel PWM.
- A channel whose pattern bit is set snaps to full brightness. A cleared channel decays by a fixed step on every tick, which gives the shifting pattern a fading "comet tail".
- Duty changes are applied only at PWM period boundaries, so no output glitches occur.

Parameters:
- CH, 8, number of LED channels.
- PWM_BITS, 8, duty and counter width. DUTY_MAX = 2^PWM_BITS-1.
- FADE_STEP, 64, decrement applied per tick to each unlit channel's duty (1..DUTY_MAX).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  high = run; low = blank and clear.
- tick  in  1  timer overflow from sequencer; an event is its rising edge.
- pattern  in  CH  LED pattern from sequencer; bit i drives channel i.
- led  out  CH  PWM outputs to Pmod pins, registered.
- active  out  1  high when any channel duty is nonzero, registered.
- tick_drop  out  1  one-cycle pulse when a tick event is merged into an already-pending one.

Behaviour:
- Reset (rst_n low at posedge clk): pwm_cnt=0, all duty=0, tick_pend=0, tick_prev=0, led=0, active=0, tick_drop=0. Reset mid-period discards all state, including a pending tick.
- PWM counter: pwm_cnt counts 0..DUTY_MAX-1, then wraps to 0. The period is DUTY_MAX clocks (255 at default).
  - Boundary cycle = the cycle with pwm_cnt == DUTY_MAX-1.
- Output: led[i] is registered from (duty[i] > pwm_cnt), giving 1-clock latency.
  - duty 0 = never high.
  - duty DUTY_MAX = high every cycle.
  - duty d = exactly d high cycles per period.
- Tick detect: tick_ev = tick & ~tick_prev, with tick_prev registered every cycle.
  - A tick held high for many cycles is one event.
- Pending flag:
  - tick_ev sets tick_pend.
  - A boundary cycle with tick_pend set (or tick_ev in that same cycle) applies the update and clears tick_pend.
  - tick_ev while tick_pend is already 1 and the cycle is not a boundary: tick_drop pulses for 1 cycle; tick_pend stays 1, so only one update occurs.
- Duty update on the boundary cycle, per channel:
  - pattern[i]=1 → duty[i] <= DUTY_MAX.
  - pattern[i]=0 → duty[i] <= (duty[i] >= FADE_STEP) ? duty[i]-FADE_STEP : 0. The subtraction saturates and never wraps.
  - pattern is sampled in the boundary cycle only.
  - New duty takes effect from pwm_cnt=0 of the next period.
- enable low:
  - pwm_cnt held at 0; all duty cleared to 0; tick_pend cleared; tick_drop=0; led=0 the next cycle.
  - tick_prev still tracks tick, so a tick already high when enable rises is not an event.
- enable rising: the counter starts from 0; the first boundary occurs DUTY_MAX clocks later.
- active: registered OR over duty != 0, updated every cycle.
- Widths: duty is PWM_BITS wide. The comparison is unsigned.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 clks with pattern=0xFF and tick toggling → led=0x00, active=0, tick_drop=0 throughout. Release rst_n with enable=1, no tick → led stays 0x00.
- Snap-on:
  - Stimulus: pattern=0x01, single tick pulse.
  - Expected: from the period after the next boundary, led[0]=1 every cycle (255/255); led[7:1]=0; active=1.
- Fade with saturation:
  - Stimulus: after snap-on, pattern=0x02, one tick per period.
  - Expected: high count per 255-clk window is led[0] 191, 127, 63, 0 and led[1] 255.
  - Once channel 0 reaches 0, it stays 0 on further ticks (no wrap to 255).
- Tick merge:
  - Stimulus: two rising edges of tick within one period.
  - Expected: exactly one duty update at the boundary and tick_drop high for exactly 1 cycle on the second edge.
  - A tick held high for 600 clks produces one update only.
- Boundary coincidence: tick rising edge in the boundary cycle (pwm_cnt=254) with pattern=0x80 → update applied that cycle; led[7] full-on starting at pwm_cnt=0 of the next period; tick_pend=0 afterwards.
- Enable/reset mid-operation:
  - Stimulus: duties nonzero, drop enable (or rst_n) for 1 clk at pwm_cnt=100.
  - Expected: led=0x00 and active=0 the next cycle, and the counter restarts from 0.
  - A tick that was pending before the drop causes no update after re-enable.
